ddr5_phy_crc_check_mc: RTL and testbench

//   Multi-device, multi-nibble DDR5 read-CRC checker for the PHY read path. Tracks each read

---
 rtl/ddr5_phy_crc_pkg.sv | 21 ++
 rtl/ddr5_phy_crc8_nib.sv | 25 ++
 rtl/ddr5_phy_crc_check_mc.sv | 107 ++++++++++
 tb/tb_ddr5_phy_crc_check_mc.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr5_phy_crc_pkg.sv
// Shared CRC-8 constants, burst FSM state type and the byte-wide CRC step
// used by the DDR5 read-CRC checker.
package ddr5_phy_crc_pkg;

   localparam logic [7:0] CRC8_POLY = 8'h07;
   localparam logic [7:0] CRC8_INIT = 8'h00;

   typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

   // Bit 7 of the byte enters the LFSR first (earlier beat, MSB-first message).
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ CRC8_POLY;
         else                c = {c[6:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/ddr5_phy_crc8_nib.sv
// One DQ-nibble CRC-8 accumulator; flags a mismatch combinationally in the
// CHECK clock so the top can register the result and load the alert timer.
module ddr5_phy_crc8_nib (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       absorb,
   input  logic       check,
   input  logic [7:0] data,
   output logic       mismatch
);
   import ddr5_phy_crc_pkg::*;

   logic [7:0] acc;

   // The first data clock seeds from the init value so no clear is needed between bursts.
   always_ff @(posedge clk) begin
      if (!rst_n)      acc <= CRC8_INIT;
      else if (start)  acc <= crc8_byte(CRC8_INIT, data);
      else if (absorb) acc <= crc8_byte(acc, data);
   end

   assign mismatch = check && (acc != data);

endmodule

// File: rtl/ddr5_phy_crc_check_mc.sv
// DDR5 PHY read-CRC checker: burst FSM, per-nibble CRC compare, alert pulse timer.
// Error statistics (counter, sticky flags, clear) are built only with DDR5_PHY_CRC_ERR_STAT_EN.
module ddr5_phy_crc_check_mc #(
   parameter int pDRAM_SIZE  = 4,
   parameter int pNUM_DEV    = 1,
   parameter int pBURST_CLKS = 8,
   parameter int pALERT_PW   = 4,
   parameter int pERR_CNT_W  = 16
) (
   input  logic                                clk_i,
   input  logic                                rst_n_i,
   input  logic                                crc_en_i,
   input  logic                                pre_rddata_valid_i,
   input  logic [2*pDRAM_SIZE*pNUM_DEV-1:0]    dfi_rddata_i,
   input  logic                                err_clr_i,
   output logic                                dfi_alert_n_o,
   output logic [pNUM_DEV*pDRAM_SIZE/4-1:0]    crc_err_nib_o,
   output logic [pERR_CNT_W-1:0]               crc_err_cnt_o,
   output logic [pNUM_DEV*pDRAM_SIZE/4-1:0]    crc_err_sticky_o,
   output logic                                proto_err_o
);
   import ddr5_phy_crc_pkg::*;

   localparam int NIB   = pNUM_DEV*pDRAM_SIZE/4;
   localparam int CNT_W = $clog2(pBURST_CLKS+1);
   localparam int AW    = $clog2(pALERT_PW+1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] beat_cnt;
   logic [AW-1:0]    alert_cnt;
   logic [NIB-1:0]   mis;
   logic             start;
   logic             any_mis;

   assign start   = (state == IDLE) && pre_rddata_valid_i && crc_en_i;
   assign any_mis = |mis;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_nxt;
   end

   // CHECK always returns to IDLE; a valid in the following clock starts the next burst from there.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = DATA;
         DATA:    if (beat_cnt == CNT_W'(pBURST_CLKS-1)) state_nxt = CHECK;
         CHECK:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i)            beat_cnt <= '0;
      else if (start)          beat_cnt <= CNT_W'(1);
      else if (state == DATA)  beat_cnt <= beat_cnt + CNT_W'(1);
      else                     beat_cnt <= '0;
   end

   for (genvar n = 0; n < NIB; n++) begin : g_nib
      ddr5_phy_crc8_nib u_nib (
         .clk      (clk_i),
         .rst_n    (rst_n_i),
         .start    (start),
         .absorb   (state == DATA),
         .check    (state == CHECK),
         .data     (dfi_rddata_i[8*n +: 8]),
         .mismatch (mis[n])
      );
   end

   // A new mismatch reloads the timer so overlapping failures extend the pulse seamlessly.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         alert_cnt     <= '0;
         crc_err_nib_o <= '0;
         proto_err_o   <= 1'b0;
      end else begin
         crc_err_nib_o <= mis;
         proto_err_o   <= (state == DATA) && pre_rddata_valid_i;
         if (any_mis)               alert_cnt <= AW'(pALERT_PW);
         else if (alert_cnt != '0)  alert_cnt <= alert_cnt - AW'(1);
      end
   end

   assign dfi_alert_n_o = (alert_cnt == '0);

`ifdef DDR5_PHY_CRC_ERR_STAT_EN
   always_ff @(posedge clk_i) begin
      if (!rst_n_i || err_clr_i) begin
         crc_err_cnt_o    <= '0;
         crc_err_sticky_o <= '0;
      end else begin
         crc_err_sticky_o <= crc_err_sticky_o | mis;
         if (any_mis && (crc_err_cnt_o != '1))
            crc_err_cnt_o <= crc_err_cnt_o + pERR_CNT_W'(1);
      end
   end
`else
   logic unused_clr;
   assign unused_clr       = err_clr_i;
   assign crc_err_cnt_o    = '0;
   assign crc_err_sticky_o = '0;
`endif

endmodule

// File: tb/tb_ddr5_phy_crc_check_mc.sv
// Directed bench for ddr5_phy_crc_check_mc: an x4 single-nibble instance and an
// x16 four-nibble instance with a 2-bit error counter for saturation.
module tb_ddr5_phy_crc_check_mc;

`ifdef DDR5_PHY_CRC_ERR_STAT_EN
   localparam bit STAT = 1'b1;
`else
   localparam bit STAT = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        en4, v4, clr4;
   logic [7:0]  d4;
   logic        alert4, nib4, sticky4, proto4;
   logic [15:0] cnt4;

   logic        en16, v16, clr16;
   logic [31:0] d16;
   logic        alert16, proto16;
   logic [3:0]  nib16, sticky16;
   logic [1:0]  cnt16;

   int vectors = 0;
   int errors  = 0;

   ddr5_phy_crc_check_mc #(.pDRAM_SIZE(4)) u_x4 (
      .clk_i(clk), .rst_n_i(rst_n), .crc_en_i(en4), .pre_rddata_valid_i(v4),
      .dfi_rddata_i(d4), .err_clr_i(clr4), .dfi_alert_n_o(alert4),
      .crc_err_nib_o(nib4), .crc_err_cnt_o(cnt4), .crc_err_sticky_o(sticky4),
      .proto_err_o(proto4)
   );

   ddr5_phy_crc_check_mc #(.pDRAM_SIZE(16), .pERR_CNT_W(2)) u_x16 (
      .clk_i(clk), .rst_n_i(rst_n), .crc_en_i(en16), .pre_rddata_valid_i(v16),
      .dfi_rddata_i(d16), .err_clr_i(clr16), .dfi_alert_n_o(alert16),
      .crc_err_nib_o(nib16), .crc_err_cnt_o(cnt16), .crc_err_sticky_o(sticky16),
      .proto_err_o(proto16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick4(input logic v, input logic [7:0] d);
      @(negedge clk);
      v4 = v;
      d4 = d;
   endtask

   task automatic data4(input logic [63:0] msg);
      for (int k = 0; k < 8; k++) tick4(k == 0, msg[63-8*k -: 8]);
   endtask

   task automatic burst4(input logic [63:0] msg, input logic [7:0] crc);
      data4(msg);
      tick4(1'b0, crc);
   endtask

   task automatic tick16(input logic v, input logic [31:0] d);
      @(negedge clk);
      v16 = v;
      d16 = d;
   endtask

   task automatic burst16(input logic [31:0] b7, input logic [31:0] crc);
      for (int k = 0; k < 7; k++) tick16(k == 0, 32'h0);
      tick16(1'b0, b7);
      tick16(1'b0, crc);
   endtask

   // Called at the negedge right after the CHECK edge: alert low 4 clocks, then high.
   task automatic alert4_pulse(input string tag);
      for (int i = 0; i < 4; i++) begin
         chk(tag, alert4, 1'b0);
         tick4(1'b0, 8'h00);
      end
      chk(tag, alert4, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0;
      en4 = 1'b1; v4 = 1'b0; clr4 = 1'b0; d4 = 8'h00;
      en16 = 1'b1; v16 = 1'b0; clr16 = 1'b0; d16 = 32'h0;
      repeat (3) @(negedge clk);

      chk("rst_alert", alert4, 1'b1);
      chk("rst_nib", nib4, 1'b0);
      chk("rst_cnt", cnt4, 16'h0);
      chk("rst_sticky", sticky4, 1'b0);
      chk("rst_proto", proto4, 1'b0);
      chk("rst_alert16", alert16, 1'b1);
      chk("rst_nib16", nib16, 4'h0);
      rst_n = 1'b1;

      // All-zero burst with CRC 0x00 passes
      burst4(64'h0, 8'h00);
      tick4(1'b0, 8'h00);
      chk("zero_alert", alert4, 1'b1);
      chk("zero_nib", nib4, 1'b0);

      // Clock 7 = 0x01 -> CRC 0x07 passes
      burst4(64'h01, 8'h07);
      tick4(1'b0, 8'h00);
      chk("one_pass_alert", alert4, 1'b1);
      chk("one_pass_nib", nib4, 1'b0);

      // Same data, CRC 0x0E fails
      burst4(64'h01, 8'h0E);
      tick4(1'b0, 8'h00);
      chk("one_fail_nib", nib4, 1'b1);
      chk("one_fail_cnt", cnt4, STAT ? 16'd1 : 16'd0);
      chk("one_fail_sticky", sticky4, STAT);
      alert4_pulse("one_fail_alert");
      chk("nib_pulse_end", nib4, 1'b0);

      // Clear statistics
      clr4 = 1'b1;
      tick4(1'b0, 8'h00);
      clr4 = 1'b0;
      tick4(1'b0, 8'h00);
      chk("clr_cnt", cnt4, 16'h0);
      chk("clr_sticky", sticky4, 1'b0);

      // Back-to-back failing bursts
      burst4(64'h01, 8'h0E);
      burst4(64'h01, 8'h0E);
      tick4(1'b0, 8'h00);
      chk("b2b_nib", nib4, 1'b1);
      alert4_pulse("b2b_alert");
      chk("b2b_cnt", cnt4, STAT ? 16'd2 : 16'd0);

      // Valid re-asserted in data clock 3
      for (int k = 0; k < 8; k++) begin
         tick4(k == 0 || k == 3, (k == 7) ? 8'h01 : 8'h00);
         if (k == 1) chk("proto_idle", proto4, 1'b0);
         if (k == 4) chk("proto_pulse", proto4, 1'b1);
         if (k == 5) chk("proto_end", proto4, 1'b0);
      end
      tick4(1'b0, 8'h0E);
      tick4(1'b0, 8'h00);
      chk("proto_burst_nib", nib4, 1'b1);
      alert4_pulse("proto_burst_alert");
      chk("proto_burst_cnt", cnt4, STAT ? 16'd3 : 16'd0);

      // Valid with crc_en low is not tracked
      en4 = 1'b0;
      burst4(64'h01, 8'h0E);
      en4 = 1'b1;
      tick4(1'b0, 8'h00);
      chk("noen_nib", nib4, 1'b0);
      chk("noen_alert", alert4, 1'b1);

      // Reset during data clock 5 of a failing burst
      for (int k = 0; k < 6; k++) tick4(k == 0, 8'h00);
      rst_n = 1'b0;
      tick4(1'b0, 8'h00);
      rst_n = 1'b1;
      chk("midrst_cnt", cnt4, 16'h0);
      tick4(1'b0, 8'h01);
      tick4(1'b0, 8'h0E);
      for (int i = 0; i < 5; i++) begin
         tick4(1'b0, 8'h00);
         chk("midrst_alert", alert4, 1'b1);
         chk("midrst_nib", nib4, 1'b0);
      end

      // err_clr coinciding with a failing CHECK
      burst4(64'h01, 8'h0E);
      tick4(1'b0, 8'h00);
      alert4_pulse("pre_clr_alert");
      chk("pre_clr_cnt", cnt4, STAT ? 16'd1 : 16'd0);
      data4(64'h01);
      @(negedge clk);
      v4 = 1'b0; d4 = 8'h0E; clr4 = 1'b1;
      tick4(1'b0, 8'h00);
      clr4 = 1'b0;
      chk("clr_win_cnt", cnt4, 16'h0);
      chk("clr_win_sticky", sticky4, 1'b0);
      chk("clr_win_nib", nib4, 1'b1);
      chk("clr_win_alert", alert4, 1'b0);

      // x16: nibble 2 carries a wrong CRC
      burst16(32'h02020202, 32'h0E000E0E);
      tick16(1'b0, 32'h0);
      chk("x16_nib", nib16, 4'b0100);
      chk("x16_alert", alert16, 1'b0);
      chk("x16_sticky", sticky16, STAT ? 4'b0100 : 4'b0000);
      chk("x16_cnt", cnt16, STAT ? 2'd1 : 2'd0);

      // x16: all nibbles correct
      burst16(32'h02020202, 32'h0E0E0E0E);
      tick16(1'b0, 32'h0);
      chk("x16_pass_nib", nib16, 4'h0);
      chk("x16_pass_alert", alert16, 1'b1);

      // x16: counter saturates at all-ones
      burst16(32'h02020202, 32'h0E000E0E);
      burst16(32'h02020202, 32'h0E000E0E);
      burst16(32'h02020202, 32'h0E000E0E);
      tick16(1'b0, 32'h0);
      chk("x16_sat_cnt", cnt16, STAT ? 2'd3 : 2'd0);
      chk("x16_sat_sticky", sticky16, STAT ? 4'b0100 : 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
